// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt-target slice.
// Build option: PLIC_PRIO_PIPE_EN registers the resolver output (adds one cycle).
package plic_pkg;

    localparam int unsigned PLIC_IRQ_NUM = 32;
    localparam int unsigned PLIC_PRIO_W  = 3;

    // Width of a source ID for n sources (at least one bit)
    function automatic int unsigned plic_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PLIC_ID_W = plic_id_width(PLIC_IRQ_NUM);

`ifdef PLIC_PRIO_PIPE_EN
    localparam int unsigned PLIC_SETTLE_CYC = 2;
`else
    localparam int unsigned PLIC_SETTLE_CYC = 1;
`endif

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } plic_state_e;

endpackage

// File: rtl/plic_prio_tree.sv
// Combinational priority select: highest priority wins, ties go to the lowest ID.
module plic_prio_tree
    import plic_pkg::*;
#(
    parameter  int unsigned N    = PLIC_IRQ_NUM,
    parameter  int unsigned W    = PLIC_PRIO_W,
    localparam int unsigned ID_W = plic_id_width(N)
) (
    input  logic [N-1:0]   cand_i,
    input  logic [N*W-1:0] prio_i,
    output logic [ID_W-1:0] id_o,
    output logic [W-1:0]   prio_o
);

    // Ascending scan with strict compare keeps the lowest ID on a tie
    always_comb begin
        id_o   = '0;
        prio_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand_i[i] && (prio_i[i*W +: W] > prio_o)) begin
                id_o   = ID_W'(i);
                prio_o = prio_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/plic_target.sv
// PLIC interrupt target: pending bits, priority resolution, claim/complete.
// Build option: PLIC_PRIO_PIPE_EN registers the resolver output; ext_irq_o and
// claim_id_o then lag one extra cycle and the post-claim settle window is 2 cycles.
module plic_target
    import plic_pkg::*;
#(
    parameter  int unsigned IRQ_NUM        = PLIC_IRQ_NUM,
    parameter  int unsigned IRQ_PRIO_WIDTH = PLIC_PRIO_W,
    localparam int unsigned ID_W           = plic_id_width(IRQ_NUM)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [IRQ_NUM-1:0]                gw_valid_i,
    output logic [IRQ_NUM-1:0]                gw_ready_o,
    output logic [IRQ_NUM-1:0]                gw_comp_o,
    input  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_NUM-1:0]                ie_i,
    input  logic [IRQ_PRIO_WIDTH-1:0]         thold_i,
    input  logic                              claim_i,
    input  logic                              complete_i,
    input  logic [ID_W-1:0]                   complete_id_i,
    output logic [ID_W-1:0]                   claim_id_o,
    output logic [IRQ_NUM-1:0]                ip_o,
    output logic                              ext_irq_o
);

    logic [IRQ_NUM-1:0]        ip_q, ip_d;
    logic [IRQ_NUM-1:0]        comp_q, comp_d;
    logic                      ext_irq_q, ext_irq_d;
    plic_state_e               state_q, state_d;
    logic                      settle_cnt_q, settle_cnt_d;
    logic                      claim_fire;

    logic [IRQ_NUM-1:0]        cand;
    logic [ID_W-1:0]           res_id, win_id;
    logic [IRQ_PRIO_WIDTH-1:0] res_prio, win_prio;

    // Source 0 is never ready; others accept while not already pending
    assign gw_ready_o = {~ip_q[IRQ_NUM-1:1], 1'b0};
    assign ip_o       = ip_q;
    assign gw_comp_o  = comp_q;
    assign ext_irq_o  = ext_irq_q;

    // Candidate sources: pending, enabled and non-zero priority
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            cand[i] = ip_q[i] & ie_i[i]
                    & (prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH] != '0);
        end
    end

    plic_prio_tree #(
        .N (IRQ_NUM),
        .W (IRQ_PRIO_WIDTH)
    ) u_prio_tree (
        .cand_i (cand),
        .prio_i (prio_i),
        .id_o   (res_id),
        .prio_o (res_prio)
    );

`ifdef PLIC_PRIO_PIPE_EN
    logic [ID_W-1:0]           win_id_q, win_id_d;
    logic [IRQ_PRIO_WIDTH-1:0] win_prio_q, win_prio_d;

    // Next value of the resolver pipeline stage
    always_comb begin
        win_id_d   = res_id;
        win_prio_d = res_prio;
    end

    // Resolver pipeline stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_id_q   <= '0;
            win_prio_q <= '0;
        end else begin
            win_id_q   <= win_id_d;
            win_prio_q <= win_prio_d;
        end
    end

    assign win_id   = win_id_q;
    assign win_prio = win_prio_q;
`else
    assign win_id   = res_id;
    assign win_prio = res_prio;
`endif

    // Claim ID is hidden while the resolver settles after a claim
    assign claim_id_o = (state_q == ST_IDLE) ? win_id : '0;

    // Next-state: claim FSM, pending bits, completion pulses, interrupt line
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        claim_fire   = 1'b0;
        ip_d         = ip_q | (gw_valid_i & gw_ready_o);
        comp_d       = '0;
        ext_irq_d    = (win_prio > thold_i);

        case (state_q)
            ST_IDLE: begin
                if (claim_i) begin
                    claim_fire   = 1'b1;
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 1'(PLIC_SETTLE_CYC - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 1'b0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Claim clear overrides a same-cycle handshake; clearing ID 0 is a no-op
        if (claim_fire) begin
            ip_d[claim_id_o] = 1'b0;
        end
        ip_d[0] = 1'b0;

        // Out-of-range, zero or disabled IDs produce no completion
        for (int unsigned i = 1; i < IRQ_NUM; i++) begin
            comp_d[i] = complete_i && (complete_id_i == ID_W'(i)) && ie_i[i];
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 1'b0;
            ip_q         <= '0;
            comp_q       <= '0;
            ext_irq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            ip_q         <= ip_d;
            comp_q       <= comp_d;
            ext_irq_q    <= ext_irq_d;
        end
    end

endmodule

// File: tb/tb_plic_target.sv
// Randomized self-checking bench for plic_target against a behavioural model.
module tb_plic_target;

    localparam int unsigned N   = 32;
    localparam int unsigned W   = 3;
    localparam int unsigned IDW = 5;
`ifdef PLIC_PRIO_PIPE_EN
    localparam bit PIPE = 1'b1;
    localparam int LAT  = 2;
`else
    localparam bit PIPE = 1'b0;
    localparam int LAT  = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   gw_valid_i;
    logic [N-1:0]   gw_ready_o;
    logic [N-1:0]   gw_comp_o;
    logic [N*W-1:0] prio_i;
    logic [N-1:0]   ie_i;
    logic [W-1:0]   thold_i;
    logic           claim_i;
    logic           complete_i;
    logic [IDW-1:0] complete_id_i;
    logic [IDW-1:0] claim_id_o;
    logic [N-1:0]   ip_o;
    logic           ext_irq_o;

    plic_target #(
        .IRQ_NUM        (N),
        .IRQ_PRIO_WIDTH (W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .gw_valid_i    (gw_valid_i),
        .gw_ready_o    (gw_ready_o),
        .gw_comp_o     (gw_comp_o),
        .prio_i        (prio_i),
        .ie_i          (ie_i),
        .thold_i       (thold_i),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .claim_id_o    (claim_id_o),
        .ip_o          (ip_o),
        .ext_irq_o     (ext_irq_o)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model state
    logic [N-1:0] m_ip;
    logic [N-1:0] m_comp;
    logic         m_ext;
    int           m_settle;
    int           m_wq_id;
    int           m_wq_prio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Highest priority among pending, enabled sources (0 if none)
    function automatic int best_prio(input logic [N-1:0] ip, input logic [N-1:0] en,
                                     input logic [N*W-1:0] pr);
        int m;
        m = 0;
        for (int i = 1; i < N; i++)
            if (ip[i] && en[i] && int'(pr[i*W +: W]) > m) m = int'(pr[i*W +: W]);
        return m;
    endfunction

    // Lowest ID holding that highest priority (0 if the priority is 0)
    function automatic int best_id(input logic [N-1:0] ip, input logic [N-1:0] en,
                                   input logic [N*W-1:0] pr);
        int bp;
        bp = best_prio(ip, en, pr);
        if (bp == 0) return 0;
        for (int i = 1; i < N; i++)
            if (ip[i] && en[i] && int'(pr[i*W +: W]) == bp) return i;
        return 0;
    endfunction

    function automatic int exp_cid();
        if (m_settle != 0) return 0;
        return PIPE ? m_wq_id : best_id(m_ip, ie_i, prio_i);
    endfunction

    task automatic model_reset();
        m_ip = '0; m_comp = '0; m_ext = 1'b0; m_settle = 0; m_wq_id = 0; m_wq_prio = 0;
    endtask

    // Check outputs against the model, then advance both across one clock edge.
    // Called at the negedge after the caller has set this cycle's inputs.
    task automatic cyc();
        int           cur, rid, rp, nset;
        logic         next_ext;
        logic [N-1:0] nip, ncomp;
        #1;
        chk("ip", ip_o, m_ip);
        chk("ready", gw_ready_o, ~m_ip & 32'hFFFF_FFFE);
        chk("ext", 32'(ext_irq_o), 32'(m_ext));
        chk("comp", gw_comp_o, m_comp);
        chk("claim_id", 32'(claim_id_o), exp_cid());

        cur      = exp_cid();
        rp       = best_prio(m_ip, ie_i, prio_i);
        rid      = best_id(m_ip, ie_i, prio_i);
        next_ext = PIPE ? (m_wq_prio > int'(thold_i)) : (rp > int'(thold_i));
        nip      = m_ip | (gw_valid_i & ~m_ip);
        nip[0]   = 1'b0;
        if (claim_i && m_settle == 0 && cur != 0) nip[cur] = 1'b0;
        nset     = (m_settle == 0) ? (claim_i ? LAT : 0) : m_settle - 1;
        ncomp    = '0;
        if (complete_i && complete_id_i != 0 && int'(complete_id_i) < N && ie_i[complete_id_i])
            ncomp[complete_id_i] = 1'b1;

        @(posedge clk);
        m_ip = nip; m_comp = ncomp; m_ext = next_ext; m_settle = nset;
        m_wq_id = rid; m_wq_prio = rp;
        @(negedge clk);
    endtask

    task automatic set_prio(input int i, input int p);
        prio_i[i*W +: W] = W'(p);
    endtask

    task automatic quiet_inputs();
        gw_valid_i = '0; claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
    endtask

    // Asynchronous reset applied mid-run; state must clear without a clock edge
    task automatic mid_reset();
        rst_i = 1'b1;
        #1;
        chk("arst_ip", ip_o, 32'h0);
        chk("arst_ext", 32'(ext_irq_o), 32'h0);
        chk("arst_comp", gw_comp_o, 32'h0);
        chk("arst_cid", 32'(claim_id_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_i = 1'b1;
        quiet_inputs();
        gw_valid_i = '1;
        prio_i = '0; ie_i = '0; thold_i = '0;
        model_reset();

        // Reset held with every gateway requesting
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ip", ip_o, 32'h0);
        chk("rst_ext", 32'(ext_irq_o), 32'h0);
        chk("rst_ready", gw_ready_o, 32'hFFFF_FFFE);
        chk("rst_cid", 32'(claim_id_o), 32'h0);
        rst_i = 1'b0;
        cyc();
        chk("post_rst_ip", ip_o, 32'hFFFF_FFFE);
        gw_valid_i = '0;
        mid_reset();

        // Single source 5, prio 3 above threshold 2
        thold_i = 3'd2; set_prio(5, 3); ie_i[5] = 1'b1;
        gw_valid_i[5] = 1'b1;
        cyc();
        gw_valid_i = '0;
        chk("a_ip5", 32'(ip_o[5]), 32'h1);
        chk("a_ext_early", 32'(ext_irq_o), 32'h0);
        repeat (LAT) cyc();
        chk("a_ext", 32'(ext_irq_o), 32'h1);
        chk("a_cid", 32'(claim_id_o), 32'd5);
        claim_i = 1'b1;
        cyc();
        claim_i = 1'b0;
        chk("a_ip5_clr", 32'(ip_o[5]), 32'h0);
        chk("a_cid_settle", 32'(claim_id_o), 32'h0);
        repeat (LAT) cyc();
        chk("a_ext_drop", 32'(ext_irq_o), 32'h0);

        // Tie between 3 and 7 at prio 4; claim repeated during the settle window
        prio_i = '0; ie_i = '0; thold_i = '0;
        set_prio(3, 4); set_prio(7, 4); ie_i[3] = 1'b1; ie_i[7] = 1'b1;
        gw_valid_i[3] = 1'b1; gw_valid_i[7] = 1'b1;
        cyc();
        gw_valid_i = '0;
        repeat (LAT) cyc();
        chk("b_cid1", 32'(claim_id_o), 32'd3);
        claim_i = 1'b1;
        cyc();
        chk("b_cid_settle", 32'(claim_id_o), 32'h0);
        cyc();
        claim_i = 1'b0;
        chk("b_ip3_clr", 32'(ip_o[3]), 32'h0);
        chk("b_ip7_kept", 32'(ip_o[7]), 32'h1);
        repeat (LAT - 1) cyc();
        chk("b_cid2", 32'(claim_id_o), 32'd7);
        claim_i = 1'b1;
        cyc();
        claim_i = 1'b0;
        repeat (LAT) cyc();
        chk("b_cid3", 32'(claim_id_o), 32'h0);
        chk("b_ip_empty", ip_o, 32'h0);

        // Threshold equal to priority: no interrupt, but claim still returns the ID
        prio_i = '0; ie_i = '0; thold_i = 3'd4;
        set_prio(2, 4); ie_i[2] = 1'b1;
        gw_valid_i[2] = 1'b1;
        cyc();
        gw_valid_i = '0;
        repeat (LAT + 1) cyc();
        chk("c_ext_thold", 32'(ext_irq_o), 32'h0);
        chk("c_cid", 32'(claim_id_o), 32'd2);

        // Claim and complete of ID 2 in the same cycle
        claim_i = 1'b1; complete_i = 1'b1; complete_id_i = 5'd2;
        cyc();
        quiet_inputs();
        chk("d_comp2", gw_comp_o, 32'h4);
        chk("d_ip2_clr", 32'(ip_o[2]), 32'h0);
        cyc();
        chk("d_comp_pulse", gw_comp_o, 32'h0);

        // Ignored completions: ID 0 and a disabled source
        complete_i = 1'b1; complete_id_i = 5'd0;
        cyc();
        chk("e_comp_id0", gw_comp_o, 32'h0);
        complete_id_i = 5'd9;
        cyc();
        complete_i = 1'b0;
        chk("e_comp_dis", gw_comp_o, 32'h0);

        // Random traffic with a mid-run reset
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) begin
                prio_i  = {$urandom, $urandom, $urandom};
                ie_i    = $urandom | $urandom;
                thold_i = W'($urandom);
            end
            gw_valid_i    = $urandom & $urandom & $urandom;
            claim_i       = ($urandom_range(0, 3) == 0);
            complete_i    = ($urandom_range(0, 2) == 0);
            complete_id_i = IDW'($urandom);
            if (k == 400) mid_reset();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/plic_target.md
# plic_target

Interrupt-target stage of the PLIC, downstream of the per-source gateways and upstream of the hart's external interrupt line. It holds the pending bits and resolves the highest-priority enabled pending source against the threshold. It drives `ext_irq_o` and implements the claim/complete protocol back to the gateways. The APB register wrapper supplies priorities, enables, threshold and claim/complete strobes; this block owns all interrupt state.

## Interface
- `IRQ_NUM`, 32: number of sources including irq0 (tied off), 2..32
- `IRQ_PRIO_WIDTH`, 3: priority width; priority 0 = never interrupts
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `gw_valid_i`  in  IRQ_NUM  gateway request per source
- `gw_ready_o`  out  IRQ_NUM  accept to gateway (handshake = valid & ready)
- `gw_comp_o`  out  IRQ_NUM  one-cycle completion pulse to gateway
- `prio_i`  in  IRQ_NUM*IRQ_PRIO_WIDTH  flattened priorities, source i at `[i*W +: W]`
- `ie_i`  in  IRQ_NUM  enable bits
- `thold_i`  in  IRQ_PRIO_WIDTH  threshold
- `claim_i`  in  1  one-cycle claim strobe (APB read of CLAIMCOMP)
- `complete_i`  in  1  one-cycle complete strobe (APB write of CLAIMCOMP)
- `complete_id_i`  in  $clog2(IRQ_NUM)  ID being completed
- `claim_id_o`  out  $clog2(IRQ_NUM)  ID returned on claim; 0 = none
- `ip_o`  out  IRQ_NUM  pending bits
- `ext_irq_o`  out  1  external interrupt to hart, registered

## Operation
- `ip[0]` constant 0; `gw_ready_o[0]`=0; `gw_ready_o[i]` = ~ip[i] for i≥1.
- Handshake on source i sets ip[i] next edge.
- Resolver: candidate = ip[i] & ie_i[i] & prio>0; winner = max priority; tie → lowest ID; no candidate → ID 0, prio 0.
- `ext_irq_o` next = winner prio > `thold_i` (strict).
- `claim_id_o` = resolved winner ID (threshold does not gate claim).
- State machine IDLE/SETTLE. Claim in IDLE clears ip[claim_id_o] (if ≠0) and enters SETTLE for the resolver latency (1 cycle without pipe, 2 with). While in SETTLE, `claim_id_o` reads 0 and claims have no effect; the FSM then returns to IDLE.
- Complete: if `complete_id_i` in 1..IRQ_NUM-1 and `ie_i` set for it → `gw_comp_o[id]`=1 the next cycle for one cycle; otherwise ignored silently.
- Same-cycle claim + complete are both honoured. Same-cycle claim clear + handshake set on the same ID: clear wins.
- Priority/enable/threshold changes take effect through the normal resolver latency; pending bits are unaffected.

## Timing
- Reset: ip=0, `ip_o`=0, `ext_irq_o`=0, `gw_comp_o`=0, state IDLE, pipeline regs 0, `claim_id_o`=0, `gw_ready_o`=all 1 except bit 0.
- Handshake at edge T → `ip_o` high from T+1. `ext_irq_o` high from T+2 without pipe, T+3 with pipe.
- `gw_comp_o` registered, asserted exactly 1 cycle after `complete_i`.
- Claim at edge T → ip bit low from T+1; valid new `claim_id_o` from T+2 (no pipe) or T+3 (pipe).
- Reset mid-operation clears all state immediately; gateways re-present requests afterwards.

## Configuration
- `PLIC_PRIO_PIPE_EN` defined: the resolver output is registered, with one extra cycle on `ext_irq_o` and `claim_id_o`, and SETTLE is 2 cycles.
- Undefined: the resolver is combinational from ip, `claim_id_o` is combinational, and SETTLE is 1 cycle.

## Structure
- `plic_pkg`: default IRQ_NUM/IRQ_PRIO_WIDTH, ID width function/localparam, FSM state enum.
- Sub-module `plic_prio_tree`: combinational max-priority/lowest-ID tree. It takes candidate mask and priorities and returns ID and priority. The optional pipeline register lives in `plic_target`.

## Test plan
- Reset with `gw_valid_i`=all 1 → during reset `ip_o`=0, `ext_irq_o`=0; after release `ip_o`=0xFFFF_FFFE next cycle.
- Source 5 prio 3, `ie_i[5]`=1, thold 2, valid pulse → `ext_irq_o`=1 at T+2 (T+3 with pipe); claim → `claim_id_o`=5, ip[5]=0, `ext_irq_o` drops.
- Sources 3 and 7 both prio 4 pending → claim returns 3, second claim after SETTLE returns 7, third returns 0.
- Thold 4, source 2 prio 4 pending → `ext_irq_o`=0 but claim returns 2.
- Complete ID 2 with `ie_i[2]`=1 → `gw_comp_o`=0x4 for one cycle. Complete ID 0, ID ≥ IRQ_NUM, or disabled source → `gw_comp_o` stays 0.
- Claim during SETTLE → `claim_id_o`=0, ip unchanged; claim + complete same cycle → both effects observed.
